comma_aligner: RTL

Receive-side word framer between the GPIO serial input pin and the 8b/10b decoder in the RX path. It synchronizes the incoming serial bit stream to `varClk` and hunts for the K28.5 comma to find the 10-bit symbol boundary. Once locked, it delivers aligned 10-bit symbols with a one-cycle strobe. Lock is held until the downstream decoder reports a run of consecutive code errors.

---
 rtl/serdes_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/comma_aligner.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared SERDES definitions: K28.5 comma codes, comma prefixes and the RX framer state encoding.
// Both the TX and RX paths import this package.
package serdes_pkg;

  localparam int SYM_W = 10;

  // Codes are written in abcdeifghj order, so bit 9 of each constant is 'a'.
  localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

  localparam logic [6:0] COMMA_PFX_RDN = 7'h7C;
  localparam logic [6:0] COMMA_PFX_RDP = 7'h03;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input such as a GPIO pin.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/comma_aligner.sv
// RX word framer: synchronizes the serial pin, hunts for K28.5 to find the 10-bit boundary
// and strobes out aligned symbols, holding lock until the decoder reports a run of errors.
module comma_aligner
  import serdes_pkg::*;
#(
  parameter int LOCK_COMMAS = 2,
  parameter int LOSS_ERRS   = 4
) (
  input  logic             varClk,
  input  logic             resetN,
  input  logic             sIn,
  input  logic             bitEn,
  input  logic             symErr,
  output logic [SYM_W-1:0] sym,
  output logic             symValid,
  output logic             isComma,
  output logic             locked,
  output logic             realign
);

  localparam logic [2:0] LOCK_N = 3'(LOCK_COMMAS);
  localparam logic [3:0] LOSS_N = 4'(LOSS_ERRS);

  logic             w_bit;
  logic [SYM_W-1:0] r_win;
  logic [3:0]       r_ph;
  logic [3:0]       w_phNext;
  logic [2:0]       r_cnt;
  logic [2:0]       w_cntNext;
  logic [3:0]       r_errCnt;
  logic [3:0]       w_errCntNext;
  align_state_e     r_state;
  align_state_e     w_stateNext;
  logic             w_comma;
  logic             w_boundary;
  logic             w_emit;
  logic             w_realign;
  logic [SYM_W-1:0] r_sym;
  logic             r_symValid;
  logic             r_isComma;
  logic             r_realign;

  sync_2ff u_sync (
    .clk  (varClk),
    .rst_n(resetN),
    .i_d  (sIn),
    .o_q  (w_bit)
  );

  assign w_comma    = (r_win[6:0] == COMMA_PFX_RDN) || (r_win[6:0] == COMMA_PFX_RDP);
  assign w_boundary = bitEn && (r_ph == 4'd9);

  always_ff @(posedge varClk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= HUNT;
      r_ph     <= 4'd0;
      r_cnt    <= 3'd0;
      r_errCnt <= 4'd0;
    end else begin
      r_state  <= w_stateNext;
      r_ph     <= w_phNext;
      r_cnt    <= w_cntNext;
      r_errCnt <= w_errCntNext;
    end
  end

  // An aligned comma in VERIFY takes the boundary branch first, so it never realigns.
  always_comb begin
    w_stateNext  = r_state;
    w_phNext     = r_ph;
    w_cntNext    = r_cnt;
    w_errCntNext = r_errCnt;
    w_emit       = 1'b0;
    w_realign    = 1'b0;
    if (bitEn) begin
      w_phNext = (r_ph == 4'd9) ? 4'd0 : r_ph + 4'd1;
    end
    unique case (r_state)
      HUNT: begin
        if (bitEn && w_comma) begin
          w_emit      = 1'b1;
          w_realign   = 1'b1;
          w_phNext    = 4'd0;
          w_cntNext   = 3'd1;
          w_stateNext = (LOCK_N == 3'd1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (w_boundary) begin
          w_emit = 1'b1;
          if (w_comma) begin
            w_cntNext = r_cnt + 3'd1;
            if (r_cnt + 3'd1 == LOCK_N) begin
              w_stateNext = LOCKED;
            end
          end
        end else if (bitEn && w_comma) begin
          w_emit    = 1'b1;
          w_realign = 1'b1;
          w_phNext  = 4'd0;
          w_cntNext = 3'd1;
        end
      end
      LOCKED: begin
        w_emit = w_boundary;
        if (r_symValid) begin
          if (!symErr) begin
            w_errCntNext = 4'd0;
          end else if (r_errCnt + 4'd1 == LOSS_N) begin
            w_stateNext  = HUNT;
            w_errCntNext = 4'd0;
            w_cntNext    = 3'd0;
          end else begin
            w_errCntNext = r_errCnt + 4'd1;
          end
        end
      end
      default: begin
        w_stateNext = HUNT;
      end
    endcase
  end

  always_ff @(posedge varClk or negedge resetN) begin
    if (!resetN) begin
      r_win      <= '0;
      r_sym      <= '0;
      r_symValid <= 1'b0;
      r_isComma  <= 1'b0;
      r_realign  <= 1'b0;
    end else begin
      if (bitEn) begin
        r_win <= {w_bit, r_win[SYM_W-1:1]};
      end
      if (w_emit) begin
        r_sym     <= r_win;
        r_isComma <= w_comma;
      end
      r_symValid <= w_emit;
      r_realign  <= w_realign;
    end
  end

  assign sym      = r_sym;
  assign symValid = r_symValid;
  assign isComma  = r_isComma;
  assign realign  = r_realign;
  assign locked   = (r_state == LOCKED);

endmodule
